// File: rtl/vga_sync_detect_pkg.sv
// rtl/vga_sync_detect_pkg.sv - shared widths, saturation value and lock FSM encoding
package vga_sync_detect_pkg;

  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] CNT_SAT = 11'd2047;
  localparam logic [CNT_W-1:0] CNT_ONE = 11'd1;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value, input logic en);
    return (en && (value != CNT_SAT)) ? value + CNT_ONE : value;
  endfunction

endpackage

// File: rtl/vga_sync_axis.sv
// rtl/vga_sync_axis.sv - one sync axis: synchronize, edge detect, measure, derive polarity/width, lock
module vga_sync_axis
  import vga_sync_detect_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_sync,
  input  logic             i_cnt_en,
  input  logic             i_meas_en,
  output logic             o_rise,
  output logic             o_int,
  output logic [CNT_W-1:0] o_end,
  output logic [CNT_W-1:0] o_width,
  output logic             o_pol,
  output logic             o_locked
);

  logic             r_sync1, r_sync2, r_dly;
  logic             r_edge, r_int, r_vld1, r_vld2, r_armed;
  logic [CNT_W-1:0] r_per, r_high, r_cap_per, r_cap_high;
  logic [CNT_W-1:0] r_prev_per, r_prev_high, r_end, r_width;
  logic             r_pol;
  lock_state_t      r_state, w_state_nxt;

  logic             w_rise, w_timeout, w_same, w_pol;
  logic [CNT_W-1:0] w_per_inc, w_high_inc, w_low, w_width;

  assign w_rise     = r_sync2 & ~r_dly;
  assign w_per_inc  = sat_inc(r_per, i_cnt_en);
  assign w_high_inc = sat_inc(r_high, i_cnt_en & r_sync2);
  assign w_timeout  = (r_per == CNT_SAT) & ~w_rise;

  assign w_low   = r_cap_per - r_cap_high;
  assign w_pol   = (r_cap_high < w_low);
  assign w_width = w_pol ? r_cap_high : w_low;
  assign w_same  = (r_cap_per == r_prev_per) && (r_cap_high == r_prev_high);

  // The edge cycle itself closes the finishing period, so captures include this cycle's increment.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_dly      <= 1'b0;
      r_edge     <= 1'b0;
      r_int      <= 1'b0;
      r_vld1     <= 1'b0;
      r_vld2     <= 1'b0;
      r_armed    <= 1'b0;
      r_per      <= '0;
      r_high     <= '0;
      r_cap_per  <= '0;
      r_cap_high <= '0;
    end else begin
      r_sync1 <= i_sync;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
      r_edge  <= w_rise;
      r_int   <= r_edge;
      r_vld1  <= w_rise & r_armed & (w_per_inc != CNT_SAT);
      r_vld2  <= r_vld1;
      if (w_rise) begin
        r_cap_per  <= w_per_inc;
        r_cap_high <= w_high_inc;
        r_per      <= '0;
        r_high     <= '0;
        r_armed    <= 1'b1;
      end else begin
        r_per  <= w_per_inc;
        r_high <= w_high_inc;
        if (w_timeout) begin
          r_armed <= 1'b0;
        end
      end
    end
  end

  // Measured outputs hold across a timeout; only the comparison history is cleared.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_end       <= '0;
      r_width     <= '0;
      r_pol       <= 1'b0;
      r_prev_per  <= '0;
      r_prev_high <= '0;
    end else if (w_timeout) begin
      r_prev_per  <= '0;
      r_prev_high <= '0;
    end else if (r_vld2 && i_meas_en) begin
      r_end       <= r_cap_per - CNT_ONE;
      r_width     <= w_width;
      r_pol       <= w_pol;
      r_prev_per  <= r_cap_per;
      r_prev_high <= r_cap_high;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_SEARCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = ST_SEARCH;
    end else if (r_vld2) begin
      if (!i_meas_en || !w_same) begin
        w_state_nxt = ST_SEARCH;
      end else begin
        case (r_state)
          ST_SEARCH: w_state_nxt = ST_CHECK;
          ST_CHECK:  w_state_nxt = ST_LOCKED;
          default:   w_state_nxt = ST_LOCKED;
        endcase
      end
    end
  end

  assign o_rise   = w_rise;
  assign o_int    = r_int;
  assign o_end    = r_end;
  assign o_width  = r_width;
  assign o_pol    = r_pol;
  assign o_locked = (r_state == ST_LOCKED);

endmodule

// File: rtl/vga_sync_detect.sv
// rtl/vga_sync_detect.sv - VGA h/v sync timing measurement and lock detection
module vga_sync_detect
  import vga_sync_detect_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_hSync,
  input  logic             i_vSync,
  output logic [CNT_W-1:0] o_hEnd,
  output logic [CNT_W-1:0] o_hSyncWidth,
  output logic             o_hSyncPol,
  output logic [CNT_W-1:0] o_vEnd,
  output logic [CNT_W-1:0] o_vSyncWidth,
  output logic             o_vSyncPol,
  output logic             o_hLocked,
  output logic             o_vLocked,
  output logic             o_locked,
  output logic             o_inth,
  output logic             o_intv
);

  logic w_h_rise, w_h_locked, w_v_locked, w_v_rise_unused;
  logic r_locked;

  vga_sync_axis u_h_axis (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_sync    (i_hSync),
    .i_cnt_en  (1'b1),
    .i_meas_en (1'b1),
    .o_rise    (w_h_rise),
    .o_int     (o_inth),
    .o_end     (o_hEnd),
    .o_width   (o_hSyncWidth),
    .o_pol     (o_hSyncPol),
    .o_locked  (w_h_locked)
  );

  // The v axis counts lines: its period/high counters advance only on h edges.
  vga_sync_axis u_v_axis (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_sync    (i_vSync),
    .i_cnt_en  (w_h_rise),
    .i_meas_en (w_h_locked),
    .o_rise    (w_v_rise_unused),
    .o_int     (o_intv),
    .o_end     (o_vEnd),
    .o_width   (o_vSyncWidth),
    .o_pol     (o_vSyncPol),
    .o_locked  (w_v_locked)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_locked <= 1'b0;
    end else begin
      r_locked <= w_h_locked & w_v_locked;
    end
  end

  assign o_hLocked = w_h_locked;
  assign o_vLocked = w_v_locked;
  assign o_locked  = r_locked;

endmodule

// File: tb/tb_vga_sync_detect.sv
// tb/tb_vga_sync_detect.sv - scoreboard bench for vga_sync_detect
module tb_vga_sync_detect;

  logic        i_clk = 1'b0;
  logic        i_reset, i_hSync, i_vSync;
  logic [10:0] o_hEnd, o_hSyncWidth, o_vEnd, o_vSyncWidth;
  logic        o_hSyncPol, o_vSyncPol, o_hLocked, o_vLocked, o_locked, o_inth, o_intv;

  typedef struct packed {
    logic [10:0] e;
    logic [10:0] w;
    logic        p;
    logic        l;
  } exp_t;

  exp_t h_q[$];
  exp_t v_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  vga_sync_detect dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_hSync      (i_hSync),
    .i_vSync      (i_vSync),
    .o_hEnd       (o_hEnd),
    .o_hSyncWidth (o_hSyncWidth),
    .o_hSyncPol   (o_hSyncPol),
    .o_vEnd       (o_vEnd),
    .o_vSyncWidth (o_vSyncWidth),
    .o_vSyncPol   (o_vSyncPol),
    .o_hLocked    (o_hLocked),
    .o_vLocked    (o_vLocked),
    .o_locked     (o_locked),
    .o_inth       (o_inth),
    .o_intv       (o_intv)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic exp_t mk(input int e, input int w, input bit p, input bit l);
    exp_t x;
    x.e = 11'(e);
    x.w = 11'(w);
    x.p = p;
    x.l = l;
    return x;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".hEnd"}, int'(o_hEnd), 0);
    chk({tag, ".hSyncWidth"}, int'(o_hSyncWidth), 0);
    chk({tag, ".hSyncPol"}, int'(o_hSyncPol), 0);
    chk({tag, ".vEnd"}, int'(o_vEnd), 0);
    chk({tag, ".vSyncWidth"}, int'(o_vSyncWidth), 0);
    chk({tag, ".vSyncPol"}, int'(o_vSyncPol), 0);
    chk({tag, ".hLocked"}, int'(o_hLocked), 0);
    chk({tag, ".vLocked"}, int'(o_vLocked), 0);
    chk({tag, ".locked"}, int'(o_locked), 0);
    chk({tag, ".inth"}, int'(o_inth), 0);
    chk({tag, ".intv"}, int'(o_intv), 0);
  endtask

  // One line: rising edge at line start, high for hi clocks, low for lo clocks.
  task automatic hline(input int hi, input int lo, input logic vlev, input exp_t hx);
    h_q.push_back(hx);
    i_vSync = vlev;
    i_hSync = 1'b1;
    repeat (hi) @(negedge i_clk);
    i_hSync = 1'b0;
    repeat (lo) @(negedge i_clk);
  endtask

  initial begin : monitor
    logic h_seen, v_seen;
    exp_t x;
    h_seen = 1'b0;
    v_seen = 1'b0;
    forever begin
      @(negedge i_clk);
      if (h_seen) begin
        chk("h_pulse_expected", int'(h_q.size() > 0), 1);
        if (h_q.size() > 0) begin
          x = h_q.pop_front();
          chk("hEnd", int'(o_hEnd), int'(x.e));
          chk("hSyncWidth", int'(o_hSyncWidth), int'(x.w));
          chk("hSyncPol", int'(o_hSyncPol), int'(x.p));
          chk("hLocked", int'(o_hLocked), int'(x.l));
        end
      end
      if (v_seen) begin
        chk("v_pulse_expected", int'(v_q.size() > 0), 1);
        if (v_q.size() > 0) begin
          x = v_q.pop_front();
          chk("vEnd", int'(o_vEnd), int'(x.e));
          chk("vSyncWidth", int'(o_vSyncWidth), int'(x.w));
          chk("vSyncPol", int'(o_vSyncPol), int'(x.p));
          chk("vLocked", int'(o_vLocked), int'(x.l));
        end
      end
      h_seen = o_inth;
      v_seen = o_intv;
    end
  end

  initial begin : stimulus
    i_reset = 1'b1;
    i_hSync = 1'b0;
    i_vSync = 1'b0;
    repeat (3) @(negedge i_clk);
    chk_zero("reset");
    i_reset = 1'b0;
    @(negedge i_clk);

    // 800/96 active-low; first line also checks o_inth latency and width
    h_q.push_back(mk(0, 0, 0, 0));
    i_hSync = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge i_clk);
      chk("inth_latency", int'(o_inth), int'(i == 4));
    end
    repeat (704 - 5) @(negedge i_clk);
    i_hSync = 1'b0;
    repeat (96) @(negedge i_clk);
    for (int k = 1; k <= 5; k++) hline(704, 96, 1'b0, mk(799, 96, 0, k >= 3));

    // hold h low: lock survives ~1800 clocks, lost by 3000, measurements hold
    repeat (1000) @(negedge i_clk);
    chk("hLocked_before_timeout", int'(o_hLocked), 1);
    repeat (2000) @(negedge i_clk);
    chk("hLocked_after_timeout", int'(o_hLocked), 0);
    chk("hEnd_hold", int'(o_hEnd), 799);
    chk("hSyncWidth_hold", int'(o_hSyncWidth), 96);

    // resume 800, then switch to 1056/128
    for (int k = 0; k <= 3; k++) hline(704, 96, 1'b0, mk(799, 96, 0, k >= 3));
    hline(928, 128, 1'b0, mk(799, 96, 0, 1));
    for (int j = 1; j <= 3; j++) hline(928, 128, 1'b0, mk(1055, 128, 0, j == 3));

    // one-cycle reset in the low part of a line
    h_q.push_back(mk(1055, 128, 0, 1));
    i_hSync = 1'b1;
    repeat (928) @(negedge i_clk);
    i_hSync = 1'b0;
    repeat (50) @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    chk_zero("midline_reset");
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (77) @(negedge i_clk);

    // reduced frame: h 100/12 low, v 25 lines/2 low, both active-low
    for (int f = 0; f < 5; f++) begin
      for (int ln = 0; ln < 25; ln++) begin
        int n;
        n = f * 25 + ln;
        if (ln == 0) v_q.push_back(mk(f == 0 ? 0 : 24, f == 0 ? 0 : 2, 0, f >= 3));
        hline(88, 12, ln < 23, mk(n == 0 ? 0 : 99, n == 0 ? 0 : 12, 0, n >= 3));
      end
    end
    chk("locked_normal", int'(o_locked), 1);
    chk("vEnd_normal", int'(o_vEnd), 24);
    chk("hSyncPol_normal", int'(o_hSyncPol), 0);

    // same timing, both polarities inverted
    for (int g = 0; g < 4; g++) begin
      for (int ln = 0; ln < 25; ln++) begin
        int n;
        n = g * 25 + ln;
        if (ln == 0) v_q.push_back(mk(24, 2, g >= 1, (g == 0) || (g == 3)));
        hline(12, 88, ln < 2, mk(99, 12, n >= 1, (n == 0) || (n >= 3)));
      end
    end
    repeat (10) @(negedge i_clk);
    chk("locked_inverted", int'(o_locked), 1);
    chk("hSyncPol_inverted", int'(o_hSyncPol), 1);
    chk("vSyncPol_inverted", int'(o_vSyncPol), 1);
    chk("h_queue_drained", h_q.size(), 0);
    chk("v_queue_drained", v_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
